line_buffer_scheduler: RTL and testbench
========================================

# line_buffer_scheduler

Ping-pong scheduler for the 2-bank, 64-pixel x 48-bit line buffer between the pixel generator (producer) and the HUB-75 driver (consumer). Tracks ownership of each bank, issues start pulses with bank select and row number to both engines, and overlaps filling one bank with scanning out the other. It also advances the 32-row scan sequence and the frame counter.

## Interface
- row_width, 5: row index width; rows 0..2^row_width-1
- frame_width, 10: frame counter width
- stall_width, 16: underrun counter width
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  permit new starts; in-flight rows always complete
- gen_start  out  1  one-cycle pulse: generator fills gen_bank with row gen_y
- gen_bank  out  1  bank being filled
- gen_y  out  row_width  row being generated
- gen_done  in  1  one-cycle pulse: fill complete
- drv_start  out  1  one-cycle pulse: driver scans drv_bank as row drv_y
- drv_bank  out  1  bank being scanned
- drv_y  out  row_width  row address for abcde
- drv_done  in  1  one-cycle pulse: scan complete
- frame_count  out  frame_width  completed frames, wraps
- underrun_count  out  stall_width  driver starvation cycles (see Configuration)

## Operation
- Per-bank state: kEmpty, kFilling, kFull, kDraining; per-bank row tag.
- wr_ptr and rd_ptr (1 bit each) alternate; fill order equals drain order.
- Generator start: at a clock edge with enable=1, bank[wr_ptr]==kEmpty and no fill in flight -> gen_start=1 next cycle, gen_bank=wr_ptr, gen_y=next_y, tag[wr_ptr]=next_y, bank→kFilling.
- gen_done accepted only while bank[wr_ptr]==kFilling: bank→kFull, wr_ptr toggles, next_y increments, 31→0 wrap.
- Driver start: at an edge with enable=1, bank[rd_ptr]==kFull and no scan in flight -> drv_start=1 next cycle, drv_bank=rd_ptr, drv_y=tag[rd_ptr], bank→kDraining.
- drv_done accepted only while bank[rd_ptr]==kDraining: bank→kEmpty, rd_ptr toggles; if tag==max row, frame_count increments (wraps).
- done pulses outside the matching busy state ignored, no state change.
- gen_done and drv_done in the same cycle (different banks): both applied.
- A bank emptied by drv_done becomes fill-eligible on the following edge, never the same edge.
- gen_bank/gen_y/drv_bank/drv_y hold until the next start of that engine.
- enable=0: no new starts; in-flight fill/scan complete and update state normally.

## Timing
- Reset: all banks kEmpty, ptrs 0, next_y 0, frame_count 0, underrun_count 0, all outputs 0.
- Reset mid-operation discards all rows in flight; later done pulses ignored until a new start.
- Start latency: 1 cycle from qualifying condition to start pulse; start outputs registered.
- done at edge N makes the freed resource usable for a start at edge N+1 (pulse visible cycle N+2).
- Steady state: every row is filled exactly once and drained exactly once, in order 0..31.

## Configuration
- LINE_BUFFER_SCHEDULER_STATS_EN defined: underrun_count increments (saturating at all-ones) every cycle with enable=1, no scan in flight, bank[rd_ptr]!=kFull, and at least one row completed since reset.
- Undefined: counter logic omitted, underrun_count tied to 0; port retained.

## Structure
- line_buffer_scheduler_pkg: BankState enum, kBankCount=2, kRowMax, default widths.
- Sub-module line_bank_tracker (one instance per bank): state + tag register, fill/drain transition inputs.
- frame_count uses the existing CascadeCounter.

## Test plan
- Reset, enable=1, gen_done 10 cycles after each gen_start, drv_done 40 cycles after each drv_start -> drv_y sequence 0,1,2,...,31,0; frame_count=1 after row 31 drains.
- Slow driver (drv_done 100 cycles) -> at most two gen_start before first drv_done; gen_bank alternates 0,1,0.
- gen_done and drv_done in same cycle -> both banks update; next gen_start and drv_start each one cycle later.
- Stray gen_done/drv_done with nothing in flight -> no state, output, or counter change.
- Reset asserted mid-fill -> all outputs 0 next cycle; first post-reset gen_start has gen_y=0, gen_bank=0.
- STATS_EN, generator stalled 20 cycles after row 0 drains -> underrun_count=20; without macro stays 0.

Source files
------------

// File: rtl/line_buffer_scheduler_pkg.sv
// rtl/line_buffer_scheduler_pkg.sv - shared types and default widths for the line buffer ping-pong scheduler
package line_buffer_scheduler_pkg;

    typedef enum logic [1:0] {
        kEmpty    = 2'd0,
        kFilling  = 2'd1,
        kFull     = 2'd2,
        kDraining = 2'd3
    } bank_state_e;

    localparam int kBankCount         = 2;
    localparam int kRowWidthDefault   = 5;
    localparam int kFrameWidthDefault = 10;
    localparam int kStallWidthDefault = 16;
    localparam int kRowMax            = (1 << kRowWidthDefault) - 1;

endpackage

// File: rtl/cascade_counter.sv
// rtl/cascade_counter.sv - wrapping up-counter with async active-high reset
module cascade_counter #(
    parameter int width = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc_i,
    output logic [width-1:0] count_o
);

    logic [width-1:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/line_bank_tracker.sv
// rtl/line_bank_tracker.sv - ownership state and row tag of one line buffer bank
module line_bank_tracker
    import line_buffer_scheduler_pkg::*;
#(
    parameter int row_width = kRowWidthDefault
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fill_start_i,
    input  logic [row_width-1:0] fill_tag_i,
    input  logic                 fill_done_i,
    input  logic                 drain_start_i,
    input  logic                 drain_done_i,
    output bank_state_e          state_o,
    output logic [row_width-1:0] tag_o
);

    bank_state_e          state_q, state_d;
    logic [row_width-1:0] tag_q, tag_d;

    // Each transition is only honoured from its own source state, so stray pulses are no-ops.
    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        case (state_q)
            kEmpty: begin
                if (fill_start_i) begin
                    state_d = kFilling;
                    tag_d   = fill_tag_i;
                end
            end
            kFilling:  if (fill_done_i)   state_d = kFull;
            kFull:     if (drain_start_i) state_d = kDraining;
            kDraining: if (drain_done_i)  state_d = kEmpty;
            default:   state_d = kEmpty;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= kEmpty;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
        end
    end

    assign state_o = state_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/line_buffer_scheduler.sv
// rtl/line_buffer_scheduler.sv - ping-pong bank scheduler between pixel generator and HUB-75 driver
// Optional underrun statistics: define LINE_BUFFER_SCHEDULER_STATS_EN.
module line_buffer_scheduler
    import line_buffer_scheduler_pkg::*;
#(
    parameter int row_width   = kRowWidthDefault,
    parameter int frame_width = kFrameWidthDefault,
    parameter int stall_width = kStallWidthDefault
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable_i,
    output logic                   gen_start_o,
    output logic                   gen_bank_o,
    output logic [row_width-1:0]   gen_y_o,
    input  logic                   gen_done_i,
    output logic                   drv_start_o,
    output logic                   drv_bank_o,
    output logic [row_width-1:0]   drv_y_o,
    input  logic                   drv_done_i,
    output logic [frame_width-1:0] frame_count_o,
    output logic [stall_width-1:0] underrun_count_o
);

    localparam logic [row_width-1:0] row_max = '1;

    bank_state_e          bank_state [kBankCount];
    logic [row_width-1:0] bank_tag   [kBankCount];

    logic                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [row_width-1:0] next_y_q, next_y_d;
    logic                 gen_start_q, gen_start_d, gen_bank_q, gen_bank_d;
    logic [row_width-1:0] gen_y_q, gen_y_d;
    logic                 drv_start_q, drv_start_d, drv_bank_q, drv_bank_d;
    logic [row_width-1:0] drv_y_q, drv_y_d;

    logic fill_busy, drain_busy, gen_go, drv_go, gen_acc, drv_acc, frame_tick;

    assign fill_busy  = (bank_state[0] == kFilling)  || (bank_state[1] == kFilling);
    assign drain_busy = (bank_state[0] == kDraining) || (bank_state[1] == kDraining);
    assign gen_go     = enable_i && (bank_state[wr_ptr_q] == kEmpty) && !fill_busy;
    assign drv_go     = enable_i && (bank_state[rd_ptr_q] == kFull) && !drain_busy;
    assign gen_acc    = gen_done_i && (bank_state[wr_ptr_q] == kFilling);
    assign drv_acc    = drv_done_i && (bank_state[rd_ptr_q] == kDraining);
    assign frame_tick = drv_acc && (bank_tag[rd_ptr_q] == row_max);

    for (genvar b = 0; b < kBankCount; b++) begin : g_bank
        line_bank_tracker #(
            .row_width(row_width)
        ) u_tracker (
            .clock        (clock),
            .reset        (reset),
            .fill_start_i (gen_go  && (wr_ptr_q == 1'(b))),
            .fill_tag_i   (next_y_q),
            .fill_done_i  (gen_acc && (wr_ptr_q == 1'(b))),
            .drain_start_i(drv_go  && (rd_ptr_q == 1'(b))),
            .drain_done_i (drv_acc && (rd_ptr_q == 1'(b))),
            .state_o      (bank_state[b]),
            .tag_o        (bank_tag[b])
        );
    end

    // Start outputs are registered; bank/row fields hold until that engine's next start.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        next_y_d    = next_y_q;
        gen_start_d = gen_go;
        gen_bank_d  = gen_bank_q;
        gen_y_d     = gen_y_q;
        drv_start_d = drv_go;
        drv_bank_d  = drv_bank_q;
        drv_y_d     = drv_y_q;
        if (gen_go) begin
            gen_bank_d = wr_ptr_q;
            gen_y_d    = next_y_q;
        end
        if (gen_acc) begin
            wr_ptr_d = ~wr_ptr_q;
            next_y_d = next_y_q + 1'b1;
        end
        if (drv_go) begin
            drv_bank_d = rd_ptr_q;
            drv_y_d    = bank_tag[rd_ptr_q];
        end
        if (drv_acc) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            next_y_q    <= '0;
            gen_start_q <= 1'b0;
            gen_bank_q  <= 1'b0;
            gen_y_q     <= '0;
            drv_start_q <= 1'b0;
            drv_bank_q  <= 1'b0;
            drv_y_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            next_y_q    <= next_y_d;
            gen_start_q <= gen_start_d;
            gen_bank_q  <= gen_bank_d;
            gen_y_q     <= gen_y_d;
            drv_start_q <= drv_start_d;
            drv_bank_q  <= drv_bank_d;
            drv_y_q     <= drv_y_d;
        end
    end

    cascade_counter #(
        .width(frame_width)
    ) u_frame_counter (
        .clock  (clock),
        .reset  (reset),
        .inc_i  (frame_tick),
        .count_o(frame_count_o)
    );

`ifdef LINE_BUFFER_SCHEDULER_STATS_EN
    logic                   row_seen_q;
    logic [stall_width-1:0] underrun_q;
    logic                   starved;

    // Starvation only counts once the pipeline has delivered a row; start-up latency is not an underrun.
    assign starved = enable_i && !drain_busy && (bank_state[rd_ptr_q] != kFull) && row_seen_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_seen_q <= 1'b0;
            underrun_q <= '0;
        end else begin
            if (drv_acc) begin
                row_seen_q <= 1'b1;
            end
            if (starved && !(&underrun_q)) begin
                underrun_q <= underrun_q + 1'b1;
            end
        end
    end

    assign underrun_count_o = underrun_q;
`else
    assign underrun_count_o = '0;
`endif

    assign gen_start_o = gen_start_q;
    assign gen_bank_o  = gen_bank_q;
    assign gen_y_o     = gen_y_q;
    assign drv_start_o = drv_start_q;
    assign drv_bank_o  = drv_bank_q;
    assign drv_y_o     = drv_y_q;

endmodule

// File: tb/tb_line_buffer_scheduler.sv
// tb/tb_line_buffer_scheduler.sv - randomized bench with a row-counting reference model for line_buffer_scheduler
`timescale 1ns/1ps
module tb_line_buffer_scheduler;

    localparam int RW = 5;
    localparam int FW = 10;
    localparam int SW = 16;
`ifdef LINE_BUFFER_SCHEDULER_STATS_EN
    localparam int STALL_EXP = 20;
`else
    localparam int STALL_EXP = 0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable_i = 1'b0;
    logic          gen_done_i = 1'b0;
    logic          drv_done_i = 1'b0;
    logic          gen_start_o, gen_bank_o, drv_start_o, drv_bank_o;
    logic [RW-1:0] gen_y_o, drv_y_o;
    logic [FW-1:0] frame_count_o;
    logic [SW-1:0] underrun_count_o;

    always #5 clock = ~clock;

    line_buffer_scheduler #(
        .row_width(RW), .frame_width(FW), .stall_width(SW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable_i        (enable_i),
        .gen_start_o     (gen_start_o),
        .gen_bank_o      (gen_bank_o),
        .gen_y_o         (gen_y_o),
        .gen_done_i      (gen_done_i),
        .drv_start_o     (drv_start_o),
        .drv_bank_o      (drv_bank_o),
        .drv_y_o         (drv_y_o),
        .drv_done_i      (drv_done_i),
        .frame_count_o   (frame_count_o),
        .underrun_count_o(underrun_count_o)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Model: rows are numbered in order; fills/drains started and completed are plain counters.
    typedef struct {int cyc; int y; int bank;} ev_t;
    ev_t glog[$];
    ev_t dlog[$];
    int  sf = 0, cf = 0, sd = 0, cd = 0, und = 0, cyc = 0;
    int  e_gy = 0, e_dy = 0, e_gb = 0, e_db = 0, e_gs = 0, e_ds = 0;
    bit  run_chk = 0;

    always @(posedge clock) begin
        bit g_ok, d_ok, g_acc, d_acc;
        if (reset) begin
            sf = 0; cf = 0; sd = 0; cd = 0; und = 0; cyc = 0;
            e_gy = 0; e_dy = 0; e_gb = 0; e_db = 0; e_gs = 0; e_ds = 0;
            glog.delete();
            dlog.delete();
        end else begin
            cyc++;
            g_ok  = enable_i && (sf == cf) && (sf - cd < 2);
            d_ok  = enable_i && (sd == cd) && (cf > sd);
            g_acc = gen_done_i && (sf > cf);
            d_acc = drv_done_i && (sd > cd);
`ifdef LINE_BUFFER_SCHEDULER_STATS_EN
            if (enable_i && (sd == cd) && (cf <= sd) && (cd > 0) && (und < 65535)) und++;
`endif
            e_gs = int'(g_ok);
            e_ds = int'(d_ok);
            if (g_ok) begin
                e_gy = sf % 32;
                e_gb = sf % 2;
                glog.push_back('{cyc, e_gy, e_gb});
                sf++;
            end
            if (d_ok) begin
                e_dy = sd % 32;
                e_db = sd % 2;
                dlog.push_back('{cyc, e_dy, e_db});
                sd++;
            end
            if (g_acc) cf++;
            if (d_acc) cd++;
        end
    end

    always @(negedge clock) begin
        if (run_chk && !reset) begin
            chk("gen_start", int'(gen_start_o), e_gs);
            chk("gen_bank", int'(gen_bank_o), e_gb);
            chk("gen_y", int'(gen_y_o), e_gy);
            chk("drv_start", int'(drv_start_o), e_ds);
            chk("drv_bank", int'(drv_bank_o), e_db);
            chk("drv_y", int'(drv_y_o), e_dy);
            chk("frame_count", int'(frame_count_o), (cd / 32) % 1024);
            chk("underrun_count", int'(underrun_count_o), und);
        end
    end

    // Engine responders: done pulse a fixed or random number of cycles after each start.
    int gcnt = 0, dcnt = 0, glat = 10, dlat = 10;
    bit stray_en = 0, rand_en = 0, stall_mode = 0;

    task automatic tick();
        @(negedge clock);
        #1;
        gen_done_i = 1'b0;
        drv_done_i = 1'b0;
        if (gcnt > 0) begin
            gcnt--;
            if (gcnt == 0) gen_done_i = 1'b1;
        end else if (stray_en && !gen_start_o && $urandom_range(0, 7) == 0) begin
            gen_done_i = 1'b1;
        end
        if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) drv_done_i = 1'b1;
        end else if (stray_en && !drv_start_o && $urandom_range(0, 7) == 0) begin
            drv_done_i = 1'b1;
        end
        if (gen_start_o)
            gcnt = (glat == 0) ? int'($urandom_range(1, 15)) : ((stall_mode && gen_y_o == 1) ? 25 : glat);
        if (drv_start_o)
            dcnt = (dlat == 0) ? int'($urandom_range(1, 15)) : dlat;
        if (rand_en) begin
            enable_i = ($urandom_range(0, 15) != 0);
            reset    = ($urandom_range(0, 599) == 0);
        end
    endtask

    task automatic reset_dut(input bit en);
        reset    = 1'b1;
        enable_i = 1'b0;
        tick();
        tick();
        gcnt     = 0;
        dcnt     = 0;
        reset    = 1'b0;
        enable_i = en;
        run_chk  = 1;
    endtask

    initial begin
        int n;
        int errs;

        // Coincident gen_done/drv_done on different banks, both latencies 10.
        glat = 10; dlat = 10;
        reset_dut(1);
        repeat (30) tick();
        chk("a_gen0_cyc", glog.size() > 0 ? glog[0].cyc : -1, 1);
        chk("a_drv0_cyc", dlog.size() > 0 ? dlog[0].cyc : -1, 13);
        chk("a_gen2_cyc", glog.size() > 2 ? glog[2].cyc : -1, 25);
        chk("a_gen2_y", glog.size() > 2 ? glog[2].y : -1, 2);
        chk("a_drv1_cyc", dlog.size() > 1 ? dlog[1].cyc : -1, 25);
        chk("a_drv1_y", dlog.size() > 1 ? dlog[1].y : -1, 1);

        // Full frame: drv_y runs 0..31,0 and frame_count reaches 1.
        glat = 10; dlat = 40;
        reset_dut(1);
        n = 0;
        while (dlog.size() < 33 && n < 2500) begin
            tick();
            n++;
        end
        tick();
        chk("b_frame_count", int'(frame_count_o), 1);
        errs = 0;
        for (int i = 0; i < 33 && i < dlog.size(); i++)
            if (dlog[i].y != i % 32) errs++;
        chk("b_drv_y_seq", dlog.size() >= 33 ? errs : -1, 0);

        // Slow driver: only two fills before the first drain completes.
        glat = 10; dlat = 100;
        reset_dut(1);
        n = 0;
        while (cd < 1 && n < 300) begin
            tick();
            n++;
        end
        chk("c_gen_before_drain", glog.size(), 2);
        repeat (4) tick();
        chk("c_bank_seq", glog.size() >= 3 ? glog[0].bank * 4 + glog[1].bank * 2 + glog[2].bank : -1, 2);
        chk("c_gen2_cyc", glog.size() >= 3 ? glog[2].cyc : -1, 115);

        // Stray done pulses with nothing in flight.
        glat = 10; dlat = 10;
        reset_dut(0);
        stray_en = 1;
        repeat (40) tick();
        stray_en = 0;
        chk("d_no_starts", glog.size() + dlog.size(), 0);
        chk("d_frame", int'(frame_count_o), 0);
        enable_i = 1'b1;
        repeat (3) tick();
        chk("d_first_gen_y", glog.size() > 0 ? glog[0].y : -1, 0);

        // Reset mid-fill; stale done pulses afterwards must be ignored.
        reset_dut(1);
        repeat (29) tick();
        chk("e_pre_gen_y", int'(gen_y_o), 2);
        reset = 1'b1;
        #1;
        chk("e_async_zero", int'({gen_start_o, gen_bank_o, gen_y_o, drv_start_o, drv_bank_o, drv_y_o}), 0);
        tick();
        tick();
        reset    = 1'b0;
        enable_i = 1'b0;
        repeat (12) tick();
        enable_i = 1'b1;
        repeat (3) tick();
        chk("e_first_gen", glog.size() > 0 ? glog[0].y * 2 + glog[0].bank : -1, 0);
        chk("e_no_drv", dlog.size(), 0);

        // Generator stalls on row 1 after row 0 drains.
        glat = 10; dlat = 5; stall_mode = 1;
        reset_dut(1);
        n = 0;
        while (cyc < 42 && n < 100) begin
            tick();
            n++;
        end
        chk("f_underrun", int'(underrun_count_o), STALL_EXP);
        stall_mode = 0;

        // Random latencies, enable drops, stray pulses and occasional resets.
        glat = 0; dlat = 0;
        reset_dut(1);
        stray_en = 1;
        rand_en  = 1;
        repeat (4000) tick();
        rand_en  = 0;
        stray_en = 0;
        reset    = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
